// File: rtl/led_pkg.sv
// Shared definitions for the LED mode sequencer and its button front end.
package led_pkg;

    // LED mux select codes
    localparam logic [1:0] MODE_DICH00    = 2'b00;
    localparam logic [1:0] MODE_DICH01    = 2'b01;
    localparam logic [1:0] MODE_SANGDAN10 = 2'b10;
    localparam logic [1:0] MODE_SPARE11   = 2'b11;

    // Default timing for the board clock
    localparam int DEFAULT_DIV       = 25_000_000;
    localparam int DEFAULT_DWELL     = 16;
    localparam int DEFAULT_DB_CYCLES = 500_000;

    // Debouncer states: released, press pending, pressed, release pending
    typedef enum logic [1:0] {
        REL,
        PWAIT,
        PRESSED,
        RWAIT
    } db_state_t;

    // Result of searching for the next enabled mode
    typedef struct packed {
        logic       found;
        logic [1:0] mode;
    } next_mode_t;

    // First enabled mode after cur, in the order cur+1, cur+2, cur+3 (mod 4).
    // The current mode itself is never a candidate.
    function automatic next_mode_t next_mode(input logic [1:0] cur, input logic [3:0] en);
        next_mode_t r;
        logic [1:0] cand;
        r.found = 1'b0;
        r.mode  = cur;
        for (int k = 1; k < 4; k++) begin
            cand = cur + 2'(k);
            if (!r.found && en[cand]) begin
                r.found = 1'b1;
                r.mode  = cand;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-FF synchronizer followed by a debounce FSM.
// 'level' is the debounced button state, 'press' a one-clock pulse per new press.
module btn_debounce
    import led_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic          synced;
    db_state_t     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          press_next;

    assign synced = sync[1];
    assign level  = (state == PRESSED) || (state == RWAIT);

    // Bring the raw button into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], btn};
        end
    end

    // State, stability counter and registered press pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= REL;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            press <= press_next;
        end
    end

    // A level change needs the input stable for DB_CYCLES clocks in a wait state;
    // bouncing back during RWAIT returns to PRESSED without a second press
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press_next = 1'b0;
        unique case (state)
            REL: begin
                if (synced) begin
                    state_next = PWAIT;
                    cnt_next   = '0;
                end
            end
            PWAIT: begin
                if (!synced) begin
                    state_next = REL;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!synced) begin
                    state_next = RWAIT;
                    cnt_next   = '0;
                end
            end
            RWAIT: begin
                if (synced) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = REL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = REL;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// Mode select controller for the LED pattern mux: steps through enabled modes on
// a debounced button press or after a dwell time, and emits the frame step pulse.
module led_mode_sequencer
    import led_pkg::*;
#(
    parameter int DIV       = DEFAULT_DIV,
    parameter int DWELL     = DEFAULT_DWELL,
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic [3:0] mode_en,
    output logic [1:0] S,
    output logic       step,
    output logic       mode_chg
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_ARM  = PW'(DIV - 2);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    logic          press;
    logic [PW-1:0] pre_cnt;
    logic [DW-1:0] dwell;
    next_mode_t    nm;
    logic [3:0]    others;
    logic          forced;
    logic          expire;
    logic          advance;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .level (),
        .press (press)
    );

    // Free-running prescaler; step is registered one count early so it is high
    // exactly while the count sits at DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            step    <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
            step    <= (pre_cnt == PRE_ARM);
        end
    end

    // Advance request: press, dwell expiry, or sitting in a disabled mode while
    // another mode is available
    always_comb begin
        nm      = next_mode(S, mode_en);
        others  = mode_en & ~(4'b0001 << S);
        forced  = !mode_en[S] && (others != 4'b0000);
        expire  = auto_en && step && (dwell == DWELL_LAST);
        advance = press || expire || forced;
    end

    // Mode register, change pulse and dwell counter; an advance with no other
    // enabled mode still restarts the dwell but leaves S alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S        <= MODE_DICH00;
            mode_chg <= 1'b0;
            dwell    <= '0;
        end else begin
            mode_chg <= 1'b0;
            if (advance) begin
                dwell <= '0;
                if (nm.found) begin
                    S        <= nm.mode;
                    mode_chg <= 1'b1;
                end
            end else if (!auto_en) begin
                dwell <= '0;
            end else if (step) begin
                dwell <= dwell + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer with a behavioural reference model:
// debounce as a run-length rule, step from a cycle count, mode search by loop.
module tb_led_mode_sequencer;

    localparam int DIV   = 4;
    localparam int DWELL = 3;
    localparam int DBC   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       auto_en = 1'b0;
    logic [3:0] mode_en = 4'b1111;
    logic [1:0] S;
    logic       step;
    logic       mode_chg;

    int vectors = 0;
    int miscompares = 0;
    int step_seen = 0;
    int chg_seen = 0;

    // reference model state
    logic       sync_q[$];
    logic       m_level;
    int         m_run;
    logic       m_press;
    logic [1:0] m_s;
    logic       m_chg;
    logic       m_step;
    int         m_dwell;
    int         m_cyc;
    logic [3:0] rnd_en;

    led_mode_sequencer #(
        .DIV       (DIV),
        .DWELL     (DWELL),
        .DB_CYCLES (DBC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_next (btn_next),
        .auto_en  (auto_en),
        .mode_en  (mode_en),
        .S        (S),
        .step     (step),
        .mode_chg (mode_chg)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic modelReset();
        sync_q.delete();
        sync_q.push_back(1'b0);
        sync_q.push_back(1'b0);
        m_level = 1'b0;
        m_run   = 0;
        m_press = 1'b0;
        m_s     = 2'b00;
        m_chg   = 1'b0;
        m_step  = 1'b0;
        m_dwell = 0;
        m_cyc   = 0;
    endtask

    // Advance the model by one rising edge using the values present before it
    task automatic modelEdge();
        logic x;
        logic p_old;
        logic st_old;
        logic expire;
        logic forced;
        logic found;
        int   cur;
        int   tgt;
        if (rst) begin
            modelReset();
            return;
        end
        p_old  = m_press;
        st_old = m_step;
        x = sync_q.pop_front();
        sync_q.push_back(btn_next);
        // debounced level flips after DBC+1 consecutive opposite samples
        m_press = 1'b0;
        if (x != m_level) begin
            m_run++;
            if (m_run == DBC + 1) begin
                m_level = x;
                m_run   = 0;
                m_press = x;
            end
        end else begin
            m_run = 0;
        end
        // mode selection
        cur    = int'(m_s);
        expire = auto_en && st_old && (m_dwell == DWELL - 1);
        forced = !mode_en[cur] && ((mode_en & ~(4'b0001 << cur)) != 4'b0000);
        m_chg  = 1'b0;
        if (p_old || expire || forced) begin
            m_dwell = 0;
            found = 1'b0;
            tgt = cur;
            for (int k = 1; k < 4; k++) begin
                if (!found && mode_en[(cur + k) % 4]) begin
                    found = 1'b1;
                    tgt = (cur + k) % 4;
                end
            end
            if (found) begin
                m_s   = 2'(tgt);
                m_chg = 1'b1;
            end
        end else if (!auto_en) begin
            m_dwell = 0;
        end else if (st_old) begin
            m_dwell++;
        end
        // step is high in every DIV-th cycle counted from reset release
        m_cyc++;
        m_step = ((m_cyc + 1) % DIV) == 0;
    endtask

    task automatic checkOutput();
        vectors++;
        assert (S === m_s) else begin
            miscompares++;
            $error("[TB] FAIL S t=%0t observed %b expected %b", $time, S, m_s);
        end
        vectors++;
        assert (step === m_step) else begin
            miscompares++;
            $error("[TB] FAIL step t=%0t observed %b expected %b", $time, step, m_step);
        end
        vectors++;
        assert (mode_chg === m_chg) else begin
            miscompares++;
            $error("[TB] FAIL mode_chg t=%0t observed %b expected %b", $time, mode_chg, m_chg);
        end
        if (step === 1'b1) step_seen++;
        if (mode_chg === 1'b1) chg_seen++;
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s t=%0t observed %0d expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput();
        end
    endtask

    task automatic applyStimulus(input logic b, input logic a, input logic [3:0] en, input int n);
        btn_next = b;
        auto_en  = a;
        mode_en  = en;
        runCycles(n);
    endtask

    // Asynchronous reset between edges, held for two edges, released after an edge
    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        runCycles(2);
        rst = 1'b0;
    endtask

    task automatic pressOnce(input logic a, input logic [3:0] en);
        applyStimulus(1'b1, a, en, 10);
        applyStimulus(1'b0, a, en, 10);
    endtask

    initial begin
        $display("[TB] led_mode_sequencer DIV=%0d DWELL=%0d DB_CYCLES=%0d", DIV, DWELL, DBC);
        modelReset();
        runCycles(3);
        checkValue("reset_S", int'(S), 0);
        rst = 1'b0;

        // idle: step every 4th clock
        step_seen = 0;
        applyStimulus(1'b0, 1'b0, 4'b1111, 12);
        checkValue("idle_steps", step_seen, 3);
        checkValue("idle_S", int'(S), 0);

        // manual cycling through all four modes
        chg_seen = 0;
        pressOnce(1'b0, 4'b1111);
        checkValue("manual_S1", int'(S), 1);
        pressOnce(1'b0, 4'b1111);
        pressOnce(1'b0, 4'b1111);
        pressOnce(1'b0, 4'b1111);
        checkValue("manual_S_wrap", int'(S), 0);
        checkValue("manual_chg_count", chg_seen, 4);

        // bounce shorter than the debounce window
        chg_seen = 0;
        repeat (5) begin
            applyStimulus(1'b1, 1'b0, 4'b1111, 2);
            applyStimulus(1'b0, 1'b0, 4'b1111, 2);
        end
        applyStimulus(1'b0, 1'b0, 4'b1111, 10);
        checkValue("bounce_chg", chg_seen, 0);
        checkValue("bounce_S", int'(S), 0);

        // disabled current mode forces exit, lone enabled mode holds
        pressOnce(1'b0, 4'b1111);
        checkValue("dis_start_S", int'(S), 1);
        applyStimulus(1'b0, 1'b0, 4'b1101, 1);
        checkValue("dis_exit_S", int'(S), 2);
        checkValue("dis_exit_chg", int'(mode_chg), 1);
        chg_seen = 0;
        applyStimulus(1'b0, 1'b0, 4'b0100, 5);
        checkValue("dis_hold_S", int'(S), 2);
        checkValue("dis_hold_chg", chg_seen, 0);

        // auto from reset with mode 2 disabled
        btn_next = 1'b0;
        auto_en  = 1'b1;
        mode_en  = 4'b1011;
        doReset();
        applyStimulus(1'b0, 1'b1, 4'b1011, 12);
        checkValue("auto_S1", int'(S), 1);
        checkValue("auto_chg1", int'(mode_chg), 1);
        applyStimulus(1'b0, 1'b1, 4'b1011, 12);
        checkValue("auto_S3", int'(S), 3);
        applyStimulus(1'b0, 1'b1, 4'b1011, 12);
        checkValue("auto_S0", int'(S), 0);

        // press coinciding with dwell expiry
        mode_en = 4'b1111;
        doReset();
        applyStimulus(1'b0, 1'b1, 4'b1111, 3);
        applyStimulus(1'b1, 1'b1, 4'b1111, 9);
        checkValue("collide_S", int'(S), 1);
        checkValue("collide_chg", int'(mode_chg), 1);
        applyStimulus(1'b1, 1'b1, 4'b1111, 1);
        checkValue("collide_single", int'(S), 1);
        applyStimulus(1'b0, 1'b1, 4'b1111, 6);

        // reset mid-dwell
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        checkValue("rst_S", int'(S), 0);
        checkValue("rst_step", int'(step), 0);
        checkValue("rst_chg", int'(mode_chg), 0);
        runCycles(2);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 4'b1111, 8);

        // randomized traffic
        for (int seg = 0; seg < 80; seg++) begin
            rnd_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : mode_en;
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), rnd_en,
                          $urandom_range(1, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_mode_sequencer.md
# led_mode_sequencer

Controller that drives the 2-bit pattern-select `S` of the LED pattern multiplexer. It advances through the four LED modes on a debounced push-button press, or automatically after a programmable dwell time. Disabled modes are skipped. It also emits the common step-enable pulse that the pattern generators use to advance one LED frame.

## Interface
Parameters:
- `DIV`, 25_000_000, clocks per `step` pulse (≥2)
- `DWELL`, 16, `step` pulses per mode in auto mode (≥1)
- `DB_CYCLES`, 500_000, consecutive stable clocks for a debounced level change (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `btn_next`  in  1  raw push-button, asynchronous to `clk`, active-high
- `auto_en`  in  1  1 = automatic advance after dwell; 0 = manual only
- `mode_en`  in  4  bit n = 1 enables mode n
- `S`  out  2  registered mode select to the LED mux
- `step`  out  1  one-clock frame-advance pulse for the pattern generators
- `mode_chg`  out  1  one-clock pulse, high in the first cycle a new `S` value is visible

One clock: `clk`. Reset `rst` is asynchronous and active-high.

## Operation
- Reset values:
  - `S`=00, `step`=0, `mode_chg`=0.
  - Prescaler=0, dwell=0, synchronizer FFs=0, debouncer in REL with count 0.
- Input path: `btn_next` passes through a 2-FF synchronizer, then the debouncer FSM.
- Debouncer FSM:
  - REL → PWAIT when the synced input = 1.
  - PWAIT → PRESSED after the input is 1 for `DB_CYCLES` consecutive clocks. On entry to PRESSED, `press` pulses for one clock.
  - PWAIT → REL if the input drops before that.
  - PRESSED → RWAIT when the input = 0.
  - RWAIT → REL after the input is 0 for `DB_CYCLES` consecutive clocks.
  - RWAIT → PRESSED if the input returns to 1 (no new press).
- Prescaler: free-running count 0..`DIV`-1. `step`=1 when count = `DIV`-1, then the count wraps to 0. It is independent of mode and `auto_en`.
- Dwell counter:
  - When `auto_en`=1, it increments on each `step`.
  - It is held at 0 while `auto_en`=0.
  - It clears to 0 on every advance.
- Advance conditions (any one is sufficient):
  - `press`;
  - `auto_en` & `step` & dwell = `DWELL`-1;
  - `mode_en[S]`=0 while any other bit of `mode_en` is set (forced exit from a disabled mode).
- Next mode: the first enabled index after `S`, in the order S+1, S+2, S+3, wrapping 3→0 (mod 4).
- No other enabled mode (only the current mode is enabled, or `mode_en`=0000): `S` holds, dwell clears, `mode_chg` stays 0.
- Simultaneous `press` and dwell expiry: a single advance by one enabled position.
- `auto_en` falling mid-dwell: dwell clears. Re-enabling restarts a full `DWELL`.
- Reset mid-operation: all state returns to reset values immediately; no `step` or `mode_chg` pulse is generated by reset.

## Timing
- `btn_next` held at 1: `press` is asserted on the edge `DB_CYCLES`+2 clocks after the first edge that samples 1 (2 sync stages plus debounce).
- `S` and `mode_chg` update on the clock edge after the advance condition, a 1-cycle latency.
- `step` period is exactly `DIV` clocks; the first `step` is high in the `DIV`th cycle after reset release.
- Auto mode: `S` changes once every `DWELL`×`DIV` clocks when no presses occur.
- Forced exit from a disabled mode: `S` changes one clock after `mode_en` is sampled with the current bit cleared.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `led_pkg`:
  - Mode constants `MODE_DICH00`=2'b00, `MODE_DICH01`=2'b01, `MODE_SANGDAN10`=2'b10, `MODE_SPARE11`=2'b11.
  - Debouncer state typedef (REL, PWAIT, PRESSED, RWAIT).
  - Default values of `DIV`, `DWELL`, `DB_CYCLES`.
- Sub-module `btn_debounce`: synchronizer plus debouncer FSM, with parameter `DB_CYCLES` and outputs `level` and `press`. It is reused for future board buttons.
- Top level: prescaler, dwell counter, next-mode search, and output registers.

## Test plan
All scenarios use `DIV`=4, `DWELL`=3, `DB_CYCLES`=5.
- Reset and idle, `auto_en`=0, `mode_en`=1111:
  - `S`=00, `mode_chg`=0.
  - `step` high every 4th clock, first pulse at cycle 4.
- Manual cycling, `auto_en`=0: 4 clean presses (each held 10 clocks, then released 10) → `S` = 01, 10, 11, 00, with `mode_chg` once per press, 8 clocks after each rising edge (7 to `press` plus 1).
- Bounce: `btn_next` toggles 1/0 every 2 clocks for 20 clocks, then holds 0 → no `press`, `S` unchanged.
- Auto, `mode_en`=1011, `auto_en`=1 from reset → `S` goes 00 → 01 → 11 → 00, one change every 12 clocks.
- Disabled current mode: with `S`=01, set `mode_en`=1101 → `S`=10 one clock later, `mode_chg`=1. Then set `mode_en`=0100 → `S` holds at 10, `mode_chg`=0.
- Collision and reset:
  - A `press` in the same cycle as dwell expiry advances `S` by exactly one enabled position.
  - Asserting `rst` mid-dwell immediately returns all outputs and counters to reset values.
